// File: rtl/rv_if_stage.sv
// rv_if_stage: instruction fetch stage with the IF/ID pipeline register.
// Owns the PC, drives a synchronous-read instruction memory, applies
// stall / redirect / flush controls from hazard detection, inserts NOP
// bubbles, and tracks fetch-miss timeouts plus a stall-cycle counter.
module rv_if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PC_write_i,
   input  logic        IF_ID_write_i,
   input  logic        IF_flush_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_rvalid_i,
   output logic [31:0] ID_pc_o,
   output logic [31:0] ID_instr_o,
   output logic        ID_valid_o,
   output logic        fetch_err_o,
   output logic [31:0] stall_cnt_o
);

   localparam int MW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [MW-1:0] MISS_LIMIT = MW'(TIMEOUT);
   localparam logic [MW-1:0] MISS_ONE   = MW'(1);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      MISS = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [MW-1:0] miss_cnt_q, miss_cnt_d;
   logic          fetch_err_q, fetch_err_d;
   logic [31:0]   stall_cnt_q, stall_cnt_d;
   logic [31:0]   id_pc_q, id_pc_d;
   logic [31:0]   id_instr_q, id_instr_d;
   logic          id_valid_q, id_valid_d;

   logic          fetch_ok;
   logic          redirect;

   // Read data is trusted only once the memory has seen a real address.
   assign fetch_ok = (state_q != BOOT) && imem_rvalid_i;
   assign redirect = branch_taken_i;

   // Next fetch address: redirect, then hold (stall or no data), then advance.
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (rst) begin
         pc_d = RESET_PC;
      end else if (redirect) begin
         pc_d = {branch_target_i[31:2], 2'b00};
      end else if (!PC_write_i || !fetch_ok) begin
         pc_d = pc_q;
      end
   end

   assign imem_addr_o = pc_d;

   // Fetch FSM: boot delay, normal running, and consecutive-miss tracking.
   // A redirect abandons whatever fetch was pending, so rvalid in that cycle
   // has no effect on the state.
   always_comb begin
      state_d    = state_q;
      miss_cnt_d = miss_cnt_q;
      if (redirect) begin
         state_d    = RUN;
         miss_cnt_d = '0;
      end else begin
         case (state_q)
            BOOT: begin
               state_d = RUN;
            end
            RUN: begin
               if (!imem_rvalid_i) begin
                  state_d    = MISS;
                  miss_cnt_d = MISS_ONE;
               end
            end
            MISS: begin
               if (imem_rvalid_i) begin
                  state_d    = RUN;
                  miss_cnt_d = '0;
               end else if (miss_cnt_q < MISS_LIMIT) begin
                  miss_cnt_d = miss_cnt_q + MISS_ONE;
               end
            end
            default: begin
               state_d    = BOOT;
               miss_cnt_d = '0;
            end
         endcase
      end
   end

   // Sticky timeout flag and saturating stall counter.
   always_comb begin
      fetch_err_d = fetch_err_q | (miss_cnt_d == MISS_LIMIT);
      stall_cnt_d = stall_cnt_q;
      if (!PC_write_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // IF/ID register: flush/redirect kill, then hold, then capture, else bubble.
   always_comb begin
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;
      id_valid_d = id_valid_q;
      if (IF_flush_i || redirect) begin
         id_pc_d    = pc_q;
         id_instr_d = NOP_INSTR;
         id_valid_d = 1'b0;
      end else if (!IF_ID_write_i) begin
         id_pc_d    = id_pc_q;
      end else if (fetch_ok) begin
         id_pc_d    = pc_q;
         id_instr_d = imem_rdata_i;
         id_valid_d = 1'b1;
      end else begin
         id_pc_d    = pc_q;
         id_instr_d = NOP_INSTR;
         id_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         miss_cnt_q  <= '0;
         fetch_err_q <= 1'b0;
         stall_cnt_q <= '0;
         id_pc_q     <= '0;
         id_instr_q  <= NOP_INSTR;
         id_valid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         miss_cnt_q  <= miss_cnt_d;
         fetch_err_q <= fetch_err_d;
         stall_cnt_q <= stall_cnt_d;
         id_pc_q     <= id_pc_d;
         id_instr_q  <= id_instr_d;
         id_valid_q  <= id_valid_d;
      end
   end

   assign ID_pc_o     = id_pc_q;
   assign ID_instr_o  = id_instr_q;
   assign ID_valid_o  = id_valid_q;
   assign fetch_err_o = fetch_err_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_rv_if_stage.sv
// tb_rv_if_stage: directed scenarios followed by randomized stimulus, all
// compared cycle by cycle against a behavioural model of the fetch stage.
module tb_rv_if_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int          TIMEOUT   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        PC_write_i;
   logic        IF_ID_write_i;
   logic        IF_flush_i;
   logic        branch_taken_i;
   logic [31:0] branch_target_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        imem_rvalid_i;
   logic [31:0] ID_pc_o;
   logic [31:0] ID_instr_o;
   logic        ID_valid_o;
   logic        fetch_err_o;
   logic [31:0] stall_cnt_o;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   logic [31:0] m_pc;
   bit          m_boot;        // first cycle after reset: memory has no data yet
   int          m_miss;        // consecutive cycles without read data
   bit          m_err;
   logic [31:0] m_stall;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_instr;
   bit          m_id_valid;

   rv_if_stage #(
      .RESET_PC (RESET_PC),
      .NOP_INSTR(NOP_INSTR),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .PC_write_i     (PC_write_i),
      .IF_ID_write_i  (IF_ID_write_i),
      .IF_flush_i     (IF_flush_i),
      .branch_taken_i (branch_taken_i),
      .branch_target_i(branch_target_i),
      .imem_addr_o    (imem_addr_o),
      .imem_rdata_i   (imem_rdata_i),
      .imem_rvalid_i  (imem_rvalid_i),
      .ID_pc_o        (ID_pc_o),
      .ID_instr_o     (ID_instr_o),
      .ID_valid_o     (ID_valid_o),
      .fetch_err_o    (fetch_err_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a deterministic word per address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A00_0003;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc       = RESET_PC;
      m_boot     = 1'b1;
      m_miss     = 0;
      m_err      = 1'b0;
      m_stall    = 32'd0;
      m_id_pc    = 32'd0;
      m_id_instr = NOP_INSTR;
      m_id_valid = 1'b0;
   endtask

   // One clock cycle: drive inputs, compare outputs, then advance the model.
   task automatic cycle(input bit r, input bit pcw, input bit ifid, input bit fl,
                        input bit br, input logic [31:0] tgt, input bit rv);
      logic [31:0] exp_addr;
      logic [31:0] rdata;
      bit          ok;
      @(posedge clk);
      #1;
      rdata           = rv ? mem_word(m_pc) : $urandom;
      rst             = r;
      PC_write_i      = pcw;
      IF_ID_write_i   = ifid;
      IF_flush_i      = fl;
      branch_taken_i  = br;
      branch_target_i = tgt;
      imem_rvalid_i   = rv;
      imem_rdata_i    = rdata;
      #1;
      ok = !m_boot && rv;
      if (r)               exp_addr = RESET_PC;
      else if (br)         exp_addr = tgt & 32'hFFFF_FFFC;
      else if (!pcw || !ok) exp_addr = m_pc;
      else                 exp_addr = m_pc + 32'd4;

      $display("cyc rst=%0b pcw=%0b ifid=%0b fl=%0b br=%0b rv=%0b addr=%08h id_pc=%08h id_v=%0b err=%0b stall=%0d",
               r, pcw, ifid, fl, br, rv, imem_addr_o, ID_pc_o, ID_valid_o, fetch_err_o, stall_cnt_o);
      check("imem_addr", imem_addr_o, exp_addr);
      check("ID_valid", {31'd0, ID_valid_o}, {31'd0, m_id_valid});
      check("ID_instr", ID_instr_o, m_id_instr);
      if (m_id_valid) check("ID_pc", ID_pc_o, m_id_pc);
      check("fetch_err", {31'd0, fetch_err_o}, {31'd0, m_err});
      check("stall_cnt", stall_cnt_o, m_stall);

      if (r) begin
         model_reset();
      end else begin
         if (fl || br) begin
            m_id_pc = m_pc; m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
         end else if (!ifid) begin
            // held
         end else if (ok) begin
            m_id_pc = m_pc; m_id_instr = rdata; m_id_valid = 1'b1;
         end else begin
            m_id_instr = NOP_INSTR; m_id_valid = 1'b0;
         end
         if (br) begin
            m_boot = 1'b0; m_miss = 0;
         end else if (m_boot) begin
            m_boot = 1'b0;
         end else if (rv) begin
            m_miss = 0;
         end else if (m_miss < TIMEOUT) begin
            m_miss = m_miss + 1;
         end
         if (m_miss == TIMEOUT) m_err = 1'b1;
         if (!pcw && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
         m_pc = exp_addr;
      end
   endtask

   initial begin
      rst = 1'b1; PC_write_i = 1'b1; IF_ID_write_i = 1'b1; IF_flush_i = 1'b0;
      branch_taken_i = 1'b0; branch_target_i = 32'd0;
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'd0;
      model_reset();
      repeat (2) @(posedge clk);

      // reset state and streaming start-up
      cycle(1, 1, 1, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0, 0, 1);
      // full stall for three cycles, then resume
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0, 1);
      // redirect to an unaligned target while stalled
      cycle(0, 0, 0, 0, 1, 32'h0000_0103, 1);
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0, 0, 1);
      // miss timeout, flag sticks after data returns
      for (int i = 0; i < TIMEOUT + 2; i++) cycle(0, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0, 0, 1);
      // address wrap at the top of memory
      cycle(0, 1, 1, 0, 1, 32'hFFFF_FFF8, 1);
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0, 0, 1);
      // flush beats IF/ID hold
      cycle(0, 1, 0, 1, 0, 0, 1);
      cycle(0, 1, 1, 0, 0, 0, 1);
      // redirect during a miss
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0, 0);
      cycle(0, 1, 1, 0, 1, 32'h0000_0200, 1);
      for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0, 1);
      // reset clears the error flag
      cycle(1, 1, 1, 0, 0, 0, 1);
      cycle(0, 1, 1, 0, 0, 0, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cycle((i % 700) == 699,
               $urandom_range(0, 7) != 0,
               $urandom_range(0, 7) != 0,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 19) == 0,
               $urandom,
               ((i % 400) < 20) ? 1'b0 : ($urandom_range(0, 5) != 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
